// File: rtl/param_adder_seq_pkg.sv
// ============================================================================
// Module : param_adder_seq_pkg
// Brief  : State encoding and index-width helper for the add sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package param_adder_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Chunk index width: clog2(n), never narrower than one bit.
   function automatic int idx_width(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/param_adder.sv
// ============================================================================
// Module : param_adder
// Brief  : SIZE-bit unsigned adder producing a sum and a carry-out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module param_adder #(
   parameter int SIZE = 2
) (
   input  logic [SIZE-1:0] i_a,
   input  logic [SIZE-1:0] i_b,
   output logic [SIZE-1:0] o_sum,
   output logic            o_carry
);

   assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

`default_nettype wire

// File: rtl/param_adder_seq.sv
// ============================================================================
// Module : param_adder_seq
// Brief  : Multi-precision adder reusing one SIZE-bit adder over WORDS cycles.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module param_adder_seq
   import param_adder_seq_pkg::*;
#(
   parameter int SIZE  = 2,
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [SIZE*WORDS-1:0] a_in,
   input  logic [SIZE*WORDS-1:0] b_in,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [SIZE*WORDS-1:0] sum_out,
   output logic                  cout
);

   localparam int c_w  = SIZE * WORDS;
   localparam int c_iw = idx_width(WORDS);
   localparam logic [c_iw-1:0] c_last_idx = c_iw'(WORDS - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [c_w-1:0]    r_a;
   logic [c_w-1:0]    r_b;
   logic [c_w-1:0]    r_res;
   logic [c_w-1:0]    r_sum;
   logic              r_carry;
   logic              r_cout;
   logic [c_iw-1:0]   r_idx;

   logic [SIZE-1:0]   w_add_sum;
   logic              w_add_carry;
   logic [SIZE:0]     w_ext;
   logic              w_chunk_carry;
   logic              w_last;
   logic [c_w-1:0]    w_res_next;

   param_adder #(.SIZE(SIZE)) u_adder (
      .i_a     (r_a[SIZE-1:0]),
      .i_b     (r_b[SIZE-1:0]),
      .o_sum   (w_add_sum),
      .o_carry (w_add_carry)
   );

   // Ripple carry is folded in after the adder; both carries can't be set at once.
   assign w_ext         = {1'b0, w_add_sum} + {{SIZE{1'b0}}, r_carry};
   assign w_chunk_carry = w_add_carry | w_ext[SIZE];
   assign w_res_next    = (r_res >> SIZE) | (c_w'(w_ext[SIZE-1:0]) << (c_w - SIZE));
   assign w_last        = (r_idx == c_last_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_next = ST_RUN;
         ST_RUN:  if (w_last) w_state_next = ST_DONE;
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a     <= a_in;
                  r_b     <= b_in;
                  r_carry <= cin;
                  r_idx   <= '0;
                  r_res   <= '0;
               end
            end
            ST_RUN: begin
               r_a     <= r_a >> SIZE;
               r_b     <= r_b >> SIZE;
               r_res   <= w_res_next;
               r_carry <= w_chunk_carry;
               r_idx   <= r_idx + c_iw'(1);
               // Visible result only moves on DONE entry, never mid-operation.
               if (w_last) begin
                  r_sum  <= w_res_next;
                  r_cout <= w_chunk_carry;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy    = (r_state != ST_IDLE);
   assign done    = (r_state == ST_DONE);
   assign sum_out = r_sum;
   assign cout    = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_param_adder_seq.sv
// ============================================================================
// Module : tb_param_adder_seq
// Brief  : Self-checking bench for param_adder_seq with SIZE=2, WORDS=4.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_param_adder_seq;

   localparam int SIZE  = 2;
   localparam int WORDS = 4;
   localparam int W     = SIZE * WORDS;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum_out;
   logic         cout;

   int n_tests;
   int n_fail;
   int cyc;

   param_adder_seq #(.SIZE(SIZE), .WORDS(WORDS)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a_in    (a_in),
      .b_in    (b_in),
      .cin     (cin),
      .busy    (busy),
      .done    (done),
      .sum_out (sum_out),
      .cout    (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL global_timeout: sim did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain (W+1)-bit addition.
   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
   endfunction

   // Drive one accepted start, then scramble operands to prove they were latched.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      a_in  = a;
      b_in  = b;
      cin   = c;
      start = 1'b1;
      tick();
      start = 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      cin   = 1'($urandom);
   endtask

   // Wait for done; lat = edges after the accepting one, 99 on timeout.
   task automatic wait_done(output int lat);
      int n;
      n = 0;
      while (!done && n < 30) begin
         tick();
         n++;
      end
      lat = done ? n : 99;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_tests++;
      if ({busy, done, cout} !== 3'b000 || sum_out !== '0) begin
         $display("FAIL reset: busy=%0b done=%0b sum=%h cout=%0b, want all 0",
                  busy, done, sum_out, cout);
         n_fail++;
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c);
      logic [W:0] exp;
      int lat;
      exp = ref_add(a, b, c);
      start_op(a, b, c);
      wait_done(lat);
      n_tests++;
      if (lat != WORDS || sum_out !== exp[W-1:0] || cout !== exp[W]) begin
         $display("FAIL %s: lat=%0d sum=%h cout=%0b, want lat=%0d sum=%h cout=%0b",
                  name, lat, sum_out, cout, WORDS, exp[W-1:0], exp[W]);
         n_fail++;
      end
      tick();
   endtask

   task automatic test_zero();
      int busy_cnt;
      int lat;
      start_op(8'h00, 8'h00, 1'b0);
      busy_cnt = 0;
      lat = 99;
      while (busy && busy_cnt < 30) begin
         if (done && lat == 99) lat = busy_cnt;
         busy_cnt++;
         tick();
      end
      n_tests++;
      if (busy_cnt != WORDS + 1 || lat != WORDS || sum_out !== 8'h00 || cout !== 1'b0) begin
         $display("FAIL zero_add: busy_cycles=%0d done_lat=%0d sum=%h cout=%0b, want 5/4/00/0",
                  busy_cnt, lat, sum_out, cout);
         n_fail++;
      end
   endtask

   task automatic test_start_while_busy();
      int dones;
      int lat;
      start_op(8'h10, 8'h01, 1'b0);
      tick();
      a_in  = 8'hAA;
      b_in  = 8'h55;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(lat);
      n_tests++;
      if (lat != WORDS - 2 || sum_out !== 8'h11 || cout !== 1'b0) begin
         $display("FAIL busy_start: lat=%0d sum=%h cout=%0b, want lat=2 sum=11 cout=0",
                  lat, sum_out, cout);
         n_fail++;
      end
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) dones++;
      end
      n_tests++;
      if (dones != 0 || busy !== 1'b0) begin
         $display("FAIL busy_start_extra: extra_done=%0d busy=%0b, want 0/0", dones, busy);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid_run();
      int dones;
      start_op(8'hF0, 8'h0F, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || sum_out !== 8'h00 || cout !== 1'b0) begin
         $display("FAIL mid_reset: busy=%0b sum=%h cout=%0b, want 0/00/0", busy, sum_out, cout);
         n_fail++;
      end
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) dones++;
         tick();
      end
      n_tests++;
      if (dones != 0) begin
         $display("FAIL mid_reset_done: done pulses=%0d, want 0", dones);
         n_fail++;
      end
      check_op("after_reset", 8'h01, 8'h02, 1'b0);
   endtask

   task automatic test_back_to_back();
      int pulses;
      int last_cyc;
      int n;
      a_in  = 8'h80;
      b_in  = 8'h80;
      cin   = 1'b0;
      start = 1'b1;
      tick();
      pulses   = 0;
      last_cyc = 0;
      n        = 0;
      while (pulses < 4 && n < 60) begin
         tick();
         n++;
         if (done) begin
            n_tests++;
            if (sum_out !== 8'h00 || cout !== 1'b1 ||
                (pulses > 0 && cyc - last_cyc != WORDS + 2)) begin
               $display("FAIL b2b_pulse%0d: sum=%h cout=%0b gap=%0d, want 00/1/%0d",
                        pulses, sum_out, cout, cyc - last_cyc, WORDS + 2);
               n_fail++;
            end
            last_cyc = cyc;
            pulses++;
         end else if (pulses > 0) begin
            n_tests++;
            if (sum_out !== 8'h00 || cout !== 1'b1) begin
               $display("FAIL b2b_stable: sum=%h cout=%0b, want 00/1", sum_out, cout);
               n_fail++;
            end
         end
      end
      start = 1'b0;
      n_tests++;
      if (pulses != 4) begin
         $display("FAIL b2b_count: pulses=%0d, want 4", pulses);
         n_fail++;
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_random();
      logic [W:0]   exp;
      logic [W:0]   prev;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      int           lat;
      prev = {cout, sum_out};
      for (int k = 0; k < 25; k++) begin
         a   = W'($urandom);
         b   = W'($urandom);
         c   = 1'($urandom);
         exp = ref_add(a, b, c);
         start_op(a, b, c);
         lat = 0;
         while (!done && lat < 30) begin
            n_tests++;
            if ({cout, sum_out} !== prev) begin
               $display("FAIL rand%0d_hold: sum=%h cout=%0b, want %h/%0b",
                        k, sum_out, cout, prev[W-1:0], prev[W]);
               n_fail++;
            end
            tick();
            lat++;
         end
         n_tests++;
         if (lat != WORDS || sum_out !== exp[W-1:0] || cout !== exp[W]) begin
            $display("FAIL rand%0d: a=%h b=%h c=%0b lat=%0d sum=%h cout=%0b, want %0d/%h/%0b",
                     k, a, b, c, lat, sum_out, cout, WORDS, exp[W-1:0], exp[W]);
            n_fail++;
         end
         prev = exp;
         for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick();
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      start   = 1'b0;
      a_in    = '0;
      b_in    = '0;
      cin     = 1'b0;
      test_reset();
      test_zero();
      check_op("full_ripple", 8'hFF, 8'h01, 1'b0);
      check_op("carry_in",    8'h5A, 8'h33, 1'b1);
      check_op("all_ones",    8'hFF, 8'hFF, 1'b1);
      test_start_while_busy();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/param_adder_seq.md
Name: param_adder_seq

Overview:
Multi-precision add sequencer. It feeds one SIZE-bit param_adder instance with WORDS successive operand chunks, LSB chunk first, and ripples the carry between chunks in a register. The result is a SIZE*WORDS-bit sum plus carry-out. It sits in front of the parameterised adder so wide additions reuse one narrow adder over several cycles, under a start/busy/done handshake.

Parameters:
SIZE, 2, chunk width in bits; also the SIZE passed to the param_adder instance.
WORDS, 4, number of chunks per operation (must be >= 1); operand width W = SIZE*WORDS.

Ports:
clk  input  1  single clock; everything is on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new addition; sampled only in IDLE.
a_in  input  W  operand A; latched on accepted start.
b_in  input  W  operand B; latched on accepted start.
cin  input  1  carry-in to chunk 0; latched on accepted start.
busy  output  1  high when state != IDLE.
done  output  1  one-cycle pulse; sum_out/cout are valid from this cycle.
sum_out  output  W  result; held until the next accepted start or reset.
cout  output  1  carry out of the top chunk; held like sum_out.

Behaviour:
- Reset (rst=1 at an edge) values:
  - state=IDLE, busy=0, done=0, sum_out=0, cout=0.
  - Chunk index=0, carry register=0, operand shift registers=0.
  - rst has priority over every other input.
- States and transitions:
  - IDLE -> RUN: on an edge with start=1. That edge latches a_in, b_in, cin, clears the index, and clears the result shift register.
  - RUN, each edge:
    - Adder inputs are the low SIZE bits of the A/B shift registers.
    - Combine the adder output with the carry register: {c2, s} = adder.sum + carry_reg (SIZE+1 bits).
    - Chunk carry = adder.carry | c2. Both can never be 1 together.
    - Shift s into the top of the result register, and shift A/B right by SIZE.
    - carry_reg <= chunk carry; index <= index+1.
    - After the edge processing index WORDS-1, go to DONE.
  - DONE: done=1, busy=1; sum_out = result register, cout = carry_reg. The next edge goes to IDLE.
- Index width is max(1, clog2(WORDS)). With WORDS=1 there is exactly one RUN edge.
- Latency:
  - Start accepted at edge T0 -> done high during the cycle after edge T0+WORDS.
  - Back in IDLE after edge T0+WORDS+1.
  - If start is held high, one operation completes every WORDS+2 cycles.
- start while busy is ignored: no latch, no effect on the operation in flight.
- Operand inputs may change freely after the accepting edge.
- sum_out/cout change only at DONE entry or reset. They never show partial results.
- Reset mid-operation: returns to IDLE next edge, no done pulse, sum_out/cout cleared.
- Arithmetic is unsigned modulo 2^W; overflow is reported only via cout.

Decomposition:
- Shared include/package holds the state encoding localparams (ST_IDLE, ST_RUN, ST_DONE; 2-bit) and a clog2 helper constant function for the index width.
- One sub-module: the existing param_adder, instantiated once with #(.SIZE(SIZE)).
- Carry-combine and FSM live in param_adder_seq; no other sub-modules.

Test Plan:
All cases use SIZE=2, WORDS=4 (W=8).
- Zero add: a=0x00, b=0x00, cin=0, start 1 cycle -> done at T0+5 edge-cycle, sum_out=0x00, cout=0, busy high for exactly 5 cycles.
- Full ripple: a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout=1.
- Carry-in: a=0x5A, b=0x33, cin=1 -> sum_out=0x8E, cout=0. Check one more with a=0xFF, b=0xFF, cin=1 -> sum_out=0xFF, cout=1.
- Start while busy: start a=0x10, b=0x01, then 2 cycles later pulse start with a=0xAA, b=0x55 -> single done, sum_out=0x11. The second request is dropped and no second done follows.
- Reset mid-run: start a=0xF0, b=0x0F, assert rst for 1 cycle at RUN index 2 -> busy=0 next cycle, done never pulses, sum_out=0x00, cout=0. A fresh start with a=0x01, b=0x02 then gives 0x03.
- Back-to-back: hold start=1 with a=0x80, b=0x80, cin=0 -> done pulses every 6 cycles, each time sum_out=0x00, cout=1. sum_out is stable between pulses.
